// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, sizes and request checking for the data memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
  localparam int DATA_W = 32;
  localparam int DEPTH = 128;
  localparam int BE_W = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  function automatic logic req_err(input logic [63:0] addr, input int depth, input logic be_any);
    return (addr >> 2) >= 64'(depth) || !be_any;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with per-byte synchronous write and registered read
module dmem_array #(
  parameter int W = 32,
  parameter int D = 128,
  parameter int IW = $clog2(D)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [W/8-1:0] be,
  input  logic [IW-1:0] idx,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [D] = '{default: '0};
  // write enabled lanes, or register the addressed word for a load
  always_ff @(posedge clk) begin
    if (en && we)
      for (int i = 0; i < W / 8; i++)
        if (be[i]) mem[idx][8*i+:8] <= wdata[8*i+:8];
    if (en && !we) rdata <= mem[idx];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated load/store responder with valid/ready handshake
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int D = DEPTH,
  parameter int ADDR_LEN = 32,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [W-1:0]        req_wdata,
  input  logic [W/8-1:0]      req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W-1:0]        rsp_rdata,
  output logic                rsp_err
);
  localparam int IW = $clog2(D);
  state_t state, state_n;
  logic [3:0] cnt;
  logic c_we, c_err, acc;
  logic [IW-1:0] c_idx;
  logic [W-1:0] c_wdata, rdata;
  logic [W/8-1:0] c_be;
  assign req_ready = state == IDLE;
  assign acc = req_valid && req_ready;
  dmem_array #(.W(W), .D(D), .IW(IW)) u_array (
    .clk(clk),
    .en(state == ACCESS && !c_err),
    .we(c_we),
    .be(c_be),
    .idx(c_idx),
    .wdata(c_wdata),
    .rdata(rdata)
  );
  // next state: wait states counted down, one access cycle, then hold the response
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = acc ? (LATENCY > 0 ? WAIT : ACCESS) : IDLE;
      WAIT:    state_n = cnt == 4'd1 ? ACCESS : WAIT;
      ACCESS:  state_n = RESP;
      RESP:    state_n = rsp_valid && rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // capture the request, run the counter, and register the response once the array output settles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      c_we <= 1'b0;
      c_err <= 1'b0;
      c_idx <= '0;
      c_wdata <= '0;
      c_be <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        cnt <= 4'(LATENCY);
        c_we <= req_we;
        c_idx <= req_addr[IW+1:2];
        c_wdata <= req_wdata;
        c_be <= req_be;
        c_err <= req_err(64'(req_addr), D, |req_be);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (state == RESP && !rsp_valid) begin
        rsp_valid <= 1'b1;
        rsp_err <= c_err;
        rsp_rdata <= c_err || c_we ? '0 : rdata;
      end else if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of two responders, LATENCY=2 and LATENCY=0
module tb_data_mem_responder;
  logic clk = 0, reset = 1;
  logic req_valid [2], req_ready [2], req_we [2], rsp_valid [2], rsp_ready [2], rsp_err [2];
  logic [31:0] req_addr [2], req_wdata [2], rsp_rdata [2];
  logic [3:0] req_be [2];
  int total = 0, bad = 0, lat;
  logic seen;
  always #5 clk = ~clk;
  data_mem_responder #(.LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );
  data_mem_responder #(.LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic wait_rsp(input int n);
    lat = 0;
    while (!rsp_valid[n] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic xfer(input int n, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input int lat_exp, input logic [31:0] rd_exp,
                      input logic e_exp, input string tag);
    @(negedge clk);
    req_valid[n] = 1;
    req_we[n] = we;
    req_addr[n] = a;
    req_wdata[n] = d;
    req_be[n] = be;
    check({tag, " ready"}, 32'(req_ready[n]), 1);
    @(posedge clk);
    #1;
    req_valid[n] = 0;
    req_addr[n] = 32'h4;
    req_wdata[n] = '1;
    wait_rsp(n);
    check({tag, " lat"}, 32'(lat), 32'(lat_exp));
    check({tag, " rdata"}, rsp_rdata[n], rd_exp);
    check({tag, " err"}, 32'(rsp_err[n]), 32'(e_exp));
    @(posedge clk);
    #1;
    check({tag, " drop"}, 32'(rsp_valid[n]), 0);
  endtask
  initial begin
    for (int n = 0; n < 2; n++) begin
      req_valid[n] = 0;
      req_we[n] = 0;
      req_addr[n] = 0;
      req_wdata[n] = 0;
      req_be[n] = 0;
      rsp_ready[n] = 1;
    end
    #8;
    for (int n = 0; n < 2; n++) begin
      check("rst req_ready", 32'(req_ready[n]), 1);
      check("rst rsp_valid", 32'(rsp_valid[n]), 0);
      check("rst rsp_rdata", rsp_rdata[n], 0);
      check("rst rsp_err", 32'(rsp_err[n]), 0);
    end
    #2 reset = 0;
    @(posedge clk);
    #1;
    check("post rst ready", 32'(req_ready[0]), 1);
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 4, 0, 0, "st full");
    xfer(0, 0, 32'h10, 0, 4'hF, 4, 32'hDEADBEEF, 0, "ld full");
    xfer(0, 1, 32'h10, 32'h00AA0000, 4'b0100, 4, 0, 0, "st lane2");
    xfer(0, 0, 32'h10, 0, 4'hF, 4, 32'hDEAABEEF, 0, "ld lane2");
    xfer(0, 0, 32'h200, 0, 4'hF, 4, 0, 1, "ld range");
    xfer(0, 1, 32'h10, 32'h11111111, 4'h0, 4, 0, 1, "st be0");
    xfer(0, 0, 32'h10, 0, 4'hF, 4, 32'hDEAABEEF, 0, "ld after err");
    rsp_ready[0] = 0;
    @(negedge clk);
    req_valid[0] = 1;
    req_we[0] = 0;
    req_addr[0] = 32'h10;
    req_be[0] = 4'hF;
    @(posedge clk);
    #1;
    req_valid[0] = 0;
    wait_rsp(0);
    check("bp lat", 32'(lat), 4);
    req_valid[0] = 1;
    req_addr[0] = 32'h20;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp valid", 32'(rsp_valid[0]), 1);
      check("bp rdata", rsp_rdata[0], 32'hDEAABEEF);
      check("bp busy", 32'(req_ready[0]), 0);
    end
    rsp_ready[0] = 1;
    @(posedge clk);
    #1;
    check("bp drop", 32'(rsp_valid[0]), 0);
    check("bp idle", 32'(req_ready[0]), 1);
    @(posedge clk);
    #1;
    req_valid[0] = 0;
    check("bp accepted", 32'(req_ready[0]), 0);
    wait_rsp(0);
    check("bp2 lat", 32'(lat), 4);
    check("bp2 rdata", rsp_rdata[0], 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    req_valid[0] = 1;
    req_we[0] = 1;
    req_addr[0] = 32'h20;
    req_wdata[0] = 32'h12345678;
    req_be[0] = 4'hF;
    @(posedge clk);
    #1;
    req_valid[0] = 0;
    @(posedge clk);
    #1;
    reset = 1;
    @(negedge clk);
    reset = 0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (rsp_valid[0]) seen = 1;
    end
    check("abort no rsp", 32'(seen), 0);
    check("abort idle", 32'(req_ready[0]), 1);
    xfer(0, 0, 32'h20, 0, 4'hF, 4, 0, 0, "abort ld");
    xfer(1, 1, 32'h20, 32'h12345678, 4'hF, 2, 0, 0, "l0 st");
    xfer(1, 0, 32'h20, 0, 4'hF, 2, 32'h12345678, 0, "l0 ld");
    xfer(1, 0, 32'h200, 0, 4'hF, 2, 0, 1, "l0 range");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
